// File: rtl/alu_cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_cdb_pkg
// Purpose  : Shared widths, ROB tag constants and inside-opcode encodings for
//            the integer execution unit and its CDB broadcast stage.
// Revision : 1.0  initial release
// ============================================================================
package alu_cdb_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int ROB_TAG_WIDTH       = 4;
    localparam int INSIDE_OPCODE_WIDTH = 6;

    localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;
    localparam logic                     TRUE         = 1'b1;
    localparam logic                     FALSE        = 1'b0;

    // Inside opcodes. The immediate-operand ALU ops (ADDI..SRAI) occupy a
    // contiguous range so operand-2 selection is a simple range test.
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] NOP      = 6'd0;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_LUI   = 6'd1;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_AUIPC = 6'd2;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_JAL   = 6'd3;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_JALR  = 6'd4;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BEQ   = 6'd5;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BNE   = 6'd6;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BLT   = 6'd7;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BGE   = 6'd8;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BLTU  = 6'd9;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_BGEU  = 6'd10;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_ADDI  = 6'd11;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLTI  = 6'd12;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLTIU = 6'd13;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_XORI  = 6'd14;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_ORI   = 6'd15;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_ANDI  = 6'd16;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLLI  = 6'd17;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SRLI  = 6'd18;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SRAI  = 6'd19;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_ADD   = 6'd20;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SUB   = 6'd21;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLL   = 6'd22;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLT   = 6'd23;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLTU  = 6'd24;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_XOR   = 6'd25;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SRL   = 6'd26;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SRA   = 6'd27;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_OR    = 6'd28;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_AND   = 6'd29;

    // True for ops whose second ALU operand is the immediate.
    function automatic logic is_imm_op(input logic [INSIDE_OPCODE_WIDTH-1:0] op);
        return (op >= OP_ADDI) && (op <= OP_SRAI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cdb_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Purpose  : Purely combinational RV32I integer datapath.
//            (op, v1, v2, imm, pc) -> (value, jump, target, known)
// Ports    : i_op      inside opcode
//            i_v1/i_v2 resolved rs1/rs2 operands
//            i_imm     sign-extended immediate
//            i_pc      instruction pc
//            o_value   rd result
//            o_jump    control transfer taken
//            o_target  next pc (pc+4 for non-control ops)
//            o_known   opcode is a recognised ALU op
// Revision : 1.0  initial release
// ============================================================================
module alu_core
    import alu_cdb_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int OP_W   = INSIDE_OPCODE_WIDTH
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_v1,
    input  logic [DATA_W-1:0] i_v2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [DATA_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_value,
    output logic              o_jump,
    output logic [DATA_W-1:0] o_target,
    output logic              o_known
);

    logic [DATA_W-1:0] w_op2;
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_pc_plus4;
    logic [DATA_W-1:0] w_pc_plus_imm;
    logic [DATA_W-1:0] w_jalr_sum;
    logic              w_eq;
    logic              w_lt_s;
    logic              w_lt_u;
    logic              w_is_branch;
    logic              w_taken;

    // Branch ops are never immediate ops, so w_op2 equals v2 for compares.
    assign w_op2         = is_imm_op(i_op) ? i_imm : i_v2;
    assign w_shamt       = w_op2[4:0];
    assign w_pc_plus4    = i_pc + DATA_W'(4);
    assign w_pc_plus_imm = i_pc + i_imm;
    assign w_jalr_sum    = i_v1 + i_imm;
    assign w_eq          = (i_v1 == w_op2);
    assign w_lt_s        = ($signed(i_v1) < $signed(w_op2));
    assign w_lt_u        = (i_v1 < w_op2);

    always_comb begin
        o_value     = '0;
        o_jump      = FALSE;
        o_target    = w_pc_plus4;
        o_known     = TRUE;
        w_is_branch = FALSE;
        w_taken     = FALSE;
        case (i_op)
            OP_LUI:   o_value = i_imm;
            OP_AUIPC: o_value = w_pc_plus_imm;
            OP_JAL: begin
                o_value  = w_pc_plus4;
                o_jump   = TRUE;
                o_target = w_pc_plus_imm;
            end
            OP_JALR: begin
                o_value  = w_pc_plus4;
                o_jump   = TRUE;
                o_target = {w_jalr_sum[DATA_W-1:1], 1'b0};
            end
            OP_BEQ:  begin w_is_branch = TRUE; w_taken = w_eq;    end
            OP_BNE:  begin w_is_branch = TRUE; w_taken = !w_eq;   end
            OP_BLT:  begin w_is_branch = TRUE; w_taken = w_lt_s;  end
            OP_BGE:  begin w_is_branch = TRUE; w_taken = !w_lt_s; end
            OP_BLTU: begin w_is_branch = TRUE; w_taken = w_lt_u;  end
            OP_BGEU: begin w_is_branch = TRUE; w_taken = !w_lt_u; end
            OP_ADDI, OP_ADD:   o_value = i_v1 + w_op2;
            OP_SUB:            o_value = i_v1 - w_op2;
            OP_SLTI, OP_SLT:   o_value = {{(DATA_W-1){1'b0}}, w_lt_s};
            OP_SLTIU, OP_SLTU: o_value = {{(DATA_W-1){1'b0}}, w_lt_u};
            OP_XORI, OP_XOR:   o_value = i_v1 ^ w_op2;
            OP_ORI, OP_OR:     o_value = i_v1 | w_op2;
            OP_ANDI, OP_AND:   o_value = i_v1 & w_op2;
            OP_SLLI, OP_SLL:   o_value = i_v1 << w_shamt;
            OP_SRLI, OP_SRL:   o_value = i_v1 >> w_shamt;
            OP_SRAI, OP_SRA:   o_value = $signed(i_v1) >>> w_shamt;
            default:           o_known = FALSE;
        endcase
        if (w_is_branch) begin
            o_jump   = w_taken;
            o_target = w_taken ? w_pc_plus_imm : w_pc_plus4;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cdb.sv
`default_nettype none
// ============================================================================
// Module   : alu_cdb
// Purpose  : Integer execution unit behind the RS issue port. Captures one
//            issued op per cycle and broadcasts {tag, value, jump, target}
//            on the ALU CDB one cycle later. ROB misbranch kills the op being
//            captured; rdy=0 freezes all state.
// Ports    : clk, rst (async, active-high), rdy (global ready)
//            in_rs_*          issued op, operands, imm, pc, ROB tag
//            in_rob_misbranch flush request
//            out_cdb_*        registered broadcast; tag 0 = no broadcast
// Revision : 1.0  initial release
// ============================================================================
module alu_cdb
    import alu_cdb_pkg::*;
#(
    parameter int DATA_W    = DATA_WIDTH,
    parameter int ROB_TAG_W = ROB_TAG_WIDTH,
    parameter int OP_W      = INSIDE_OPCODE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [OP_W-1:0]      in_rs_op,
    input  logic [DATA_W-1:0]    in_rs_value1,
    input  logic [DATA_W-1:0]    in_rs_value2,
    input  logic [DATA_W-1:0]    in_rs_imm,
    input  logic [ROB_TAG_W-1:0] in_rs_rob_tag,
    input  logic [DATA_W-1:0]    in_rs_pc,
    input  logic                 in_rob_misbranch,
    output logic [ROB_TAG_W-1:0] out_cdb_tag,
    output logic [DATA_W-1:0]    out_cdb_value,
    output logic                 out_cdb_jump,
    output logic [DATA_W-1:0]    out_cdb_target
);

    logic [DATA_W-1:0]    w_value;
    logic                 w_jump;
    logic [DATA_W-1:0]    w_target;
    logic                 w_known;
    logic                 w_capture;

    logic [ROB_TAG_W-1:0] r_tag;
    logic [DATA_W-1:0]    r_value;
    logic                 r_jump;
    logic [DATA_W-1:0]    r_target;

    alu_core #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_core (
        .i_op     (in_rs_op),
        .i_v1     (in_rs_value1),
        .i_v2     (in_rs_value2),
        .i_imm    (in_rs_imm),
        .i_pc     (in_rs_pc),
        .o_value  (w_value),
        .o_jump   (w_jump),
        .o_target (w_target),
        .o_known  (w_known)
    );

    // Unknown opcodes fall out through w_known and behave like NOP.
    assign w_capture = !in_rob_misbranch && w_known &&
                       (in_rs_op != OP_W'(NOP)) &&
                       (in_rs_rob_tag != ZERO_TAG_ROB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag    <= '0;
            r_value  <= '0;
            r_jump   <= 1'b0;
            r_target <= '0;
        end else if (rdy) begin
            if (w_capture) begin
                r_tag    <= in_rs_rob_tag;
                r_value  <= w_value;
                r_jump   <= w_jump;
                r_target <= w_target;
            end else begin
                // Value/target are left as-is; only tag and jump must clear.
                r_tag  <= ZERO_TAG_ROB;
                r_jump <= FALSE;
            end
        end
    end

    assign out_cdb_tag    = r_tag;
    assign out_cdb_value  = r_value;
    assign out_cdb_jump   = r_jump;
    assign out_cdb_target = r_target;

endmodule
`default_nettype wire

// File: tb/tb_alu_cdb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cdb
// Purpose  : Directed self-checking bench for alu_cdb.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_cdb;
    import alu_cdb_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [3:0]  tag;
    logic [31:0] pc;
    logic        mis;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_jump;
    logic [31:0] cdb_target;

    int n_checks;
    int n_pass;

    alu_cdb dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_rs_op         (op),
        .in_rs_value1     (v1),
        .in_rs_value2     (v2),
        .in_rs_imm        (imm),
        .in_rs_rob_tag    (tag),
        .in_rs_pc         (pc),
        .in_rob_misbranch (mis),
        .out_cdb_tag      (cdb_tag),
        .out_cdb_value    (cdb_value),
        .out_cdb_jump     (cdb_jump),
        .out_cdb_target   (cdb_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, obs, exp);
    endtask

    // Drive one op at the falling edge, then step past the next rising edge.
    task automatic issue(input logic [5:0] i_op, input logic [31:0] i_v1,
                         input logic [31:0] i_v2, input logic [31:0] i_imm,
                         input logic [31:0] i_pc, input logic [3:0] i_tag,
                         input logic i_mis);
        @(negedge clk);
        op = i_op; v1 = i_v1; v2 = i_v2; imm = i_imm; pc = i_pc; tag = i_tag; mis = i_mis;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; rdy = 1'b1; op = NOP; v1 = '0; v2 = '0; imm = '0;
        tag = '0; pc = '0; mis = 1'b0;

        // Reset takes effect before any clock edge.
        #2;
        check_eq("rst_tag",    32'(cdb_tag),  32'h0);
        check_eq("rst_value",  cdb_value,     32'h0);
        check_eq("rst_jump",   32'(cdb_jump), 32'h0);
        check_eq("rst_target", cdb_target,    32'h0);

        @(negedge clk); rst = 1'b0;
        issue(NOP, 32'h1, 32'h2, 32'h3, 32'h4, 4'd5, 1'b0);
        check_eq("nop_tag0", 32'(cdb_tag), 32'h0);
        issue(NOP, 32'h1, 32'h2, 32'h3, 32'h4, 4'd6, 1'b0);
        check_eq("nop_tag1", 32'(cdb_tag), 32'h0);

        issue(OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h200, 4'd3, 1'b0);
        check_eq("add_tag",    32'(cdb_tag),  32'h3);
        check_eq("add_value",  cdb_value,     32'h0);
        check_eq("add_jump",   32'(cdb_jump), 32'h0);
        check_eq("add_target", cdb_target,    32'h204);

        issue(OP_SRA, 32'h80000000, 32'h4, 32'h0, 32'h0, 4'd4, 1'b0);
        check_eq("sra_tag",   32'(cdb_tag), 32'h4);
        check_eq("sra_value", cdb_value,    32'hF8000000);
        issue(OP_SLTU, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd5, 1'b0);
        check_eq("sltu_value", cdb_value, 32'h1);
        issue(OP_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'd6, 1'b0);
        check_eq("slt_value", cdb_value, 32'h0);
        issue(OP_SUB, 32'h5, 32'h7, 32'h0, 32'h0, 4'd1, 1'b0);
        check_eq("sub_value", cdb_value, 32'hFFFFFFFE);
        issue(OP_XORI, 32'hFF00FF00, 32'h0, 32'hFFFFFFFF, 32'h0, 4'd2, 1'b0);
        check_eq("xori_value", cdb_value, 32'h00FF00FF);
        issue(OP_SLLI, 32'h3, 32'h0, 32'h21, 32'h0, 4'd3, 1'b0);
        check_eq("slli_shamt5", cdb_value, 32'h6);
        issue(OP_SRAI, 32'h80000000, 32'h0, 32'h1F, 32'h0, 4'd4, 1'b0);
        check_eq("srai_value", cdb_value, 32'hFFFFFFFF);
        issue(OP_SRLI, 32'h80000000, 32'h0, 32'h1F, 32'h0, 4'd5, 1'b0);
        check_eq("srli_value", cdb_value, 32'h1);
        issue(OP_LUI, 32'h0, 32'h0, 32'h12345000, 32'h0, 4'd6, 1'b0);
        check_eq("lui_value", cdb_value, 32'h12345000);
        issue(OP_AUIPC, 32'h0, 32'h0, 32'h2000, 32'h1000, 4'd7, 1'b0);
        check_eq("auipc_value", cdb_value, 32'h3000);

        issue(OP_BLT, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 4'd2, 1'b0);
        check_eq("blt_tag",    32'(cdb_tag),  32'h2);
        check_eq("blt_jump",   32'(cdb_jump), 32'h1);
        check_eq("blt_target", cdb_target,    32'h120);
        check_eq("blt_value",  cdb_value,     32'h0);
        issue(OP_BLTU, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 4'd3, 1'b0);
        check_eq("bltu_jump",   32'(cdb_jump), 32'h0);
        check_eq("bltu_target", cdb_target,    32'h104);
        issue(OP_BGE, 32'hFFFFFFFF, 32'h0, 32'h20, 32'h100, 4'd4, 1'b0);
        check_eq("bge_jump", 32'(cdb_jump), 32'h0);
        issue(OP_BEQ, 32'h55, 32'h55, 32'h10, 32'h300, 4'd5, 1'b0);
        check_eq("beq_target", cdb_target, 32'h310);

        issue(OP_JALR, 32'h1001, 32'h0, 32'h2, 32'h40, 4'd5, 1'b0);
        check_eq("jalr_tag",    32'(cdb_tag),  32'h5);
        check_eq("jalr_value",  cdb_value,     32'h44);
        check_eq("jalr_jump",   32'(cdb_jump), 32'h1);
        check_eq("jalr_target", cdb_target,    32'h1002);
        issue(OP_JAL, 32'h0, 32'h0, 32'hFFFFFFF8, 32'h40, 4'd6, 1'b0);
        check_eq("jal_value",  cdb_value,     32'h44);
        check_eq("jal_jump",   32'(cdb_jump), 32'h1);
        check_eq("jal_target", cdb_target,    32'h38);

        // Flush follows a taken jump so the jump bit must also clear.
        issue(OP_ADDI, 32'h1, 32'h0, 32'h1, 32'h0, 4'd7, 1'b1);
        check_eq("flush_tag",  32'(cdb_tag),  32'h0);
        check_eq("flush_jump", 32'(cdb_jump), 32'h0);
        issue(OP_JAL, 32'h0, 32'h0, 32'h8, 32'h0, 4'd6, 1'b0);
        issue(6'd40, 32'h1, 32'h1, 32'h1, 32'h0, 4'd8, 1'b0);
        check_eq("unknown_tag",  32'(cdb_tag),  32'h0);
        check_eq("unknown_jump", 32'(cdb_jump), 32'h0);
        issue(OP_ADD, 32'h1, 32'h1, 32'h0, 32'h0, 4'd0, 1'b0);
        check_eq("tag0_tag", 32'(cdb_tag), 32'h0);

        issue(OP_ADD, 32'h10, 32'h1, 32'h0, 32'h0, 4'd1, 1'b0);
        check_eq("b2b_tag1", 32'(cdb_tag), 32'h1);
        issue(OP_ADD, 32'h10, 32'h2, 32'h0, 32'h0, 4'd2, 1'b0);
        check_eq("b2b_tag2", 32'(cdb_tag), 32'h2);
        issue(OP_ADD, 32'h10, 32'h3, 32'h0, 32'h0, 4'd3, 1'b0);
        check_eq("b2b_tag3",   32'(cdb_tag), 32'h3);
        check_eq("b2b_value3", cdb_value,    32'h13);

        // Stall: broadcast for tag 9 persists while rdy is low.
        issue(OP_ADD, 32'h5, 32'h6, 32'h0, 32'h0, 4'd9, 1'b0);
        check_eq("stall_pre_tag", 32'(cdb_tag), 32'h9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rdy = 1'b0;
            op  = (i == 1) ? NOP : OP_SUB;
            tag = 4'(10 + i);
            @(posedge clk); #1;
            check_eq("stall_tag",   32'(cdb_tag), 32'h9);
            check_eq("stall_value", cdb_value,    32'hB);
        end
        @(negedge clk);
        rdy = 1'b1; op = OP_ORI; v1 = 32'hF0; imm = 32'h0F; tag = 4'd10;
        @(posedge clk); #1;
        check_eq("resume_tag",   32'(cdb_tag), 32'hA);
        check_eq("resume_value", cdb_value,    32'hFF);

        // Async reset in the middle of a cycle with a jump on the CDB.
        issue(OP_JAL, 32'h0, 32'h0, 32'h8, 32'h80, 4'd4, 1'b0);
        @(negedge clk);
        op = NOP;
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_tag",    32'(cdb_tag),  32'h0);
        check_eq("midrst_value",  cdb_value,     32'h0);
        check_eq("midrst_jump",   32'(cdb_jump), 32'h0);
        check_eq("midrst_target", cdb_target,    32'h0);
        @(negedge clk); rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
